// File: rtl/nano_imem.sv
// Byte-loaded instruction memory with program-load FSM and core reset control.
// Define NANO_IMEM_BOUNDS_CHECK_EN to enable out-of-range fetch detection in RUN.
module nano_imem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  input  logic [7:0]        i_ld_data,
  output logic              o_ld_ready,
  input  logic              i_ld_done,
  input  logic [31:0]       i_pc,
  output logic [31:0]       o_inst,
  output logic              o_core_rst,
  output logic [ADDR_W:0]   o_load_cnt,
  output logic              o_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]        state;
  logic [1:0]        bidx;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   cnt;
  logic [23:0]       lanes;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              start_ok;
  logic              we;
  logic [31:0]       wdata;

  assign o_ld_ready = (state == S_LOAD) &&
                      (cnt < (ADDR_W+1)'(DEPTH));
  assign accept     = o_ld_ready && i_ld_valid;
  assign start_ok   = i_ld_start &&
                      (state == S_IDLE || state == S_RUN);
  assign o_core_rst = (state != S_RUN);
  assign o_load_cnt = cnt;

  // Lanes above the byte index are always zero, so FLUSH zero-fills for free.
  assign we    = (accept && bidx == 2'd3) || (state == S_FLUSH);
  assign wdata = (state == S_FLUSH) ? {8'h00, lanes}
                                    : {i_ld_data, lanes};

  always_ff @(posedge i_clk) begin
    if (we && !i_rst) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      bidx  <= 2'd0;
      wptr  <= '0;
      cnt   <= '0;
      lanes <= '0;
    end else begin
      case (state)
        S_IDLE, S_RUN: begin
          if (start_ok) begin
            state <= S_LOAD;
            bidx  <= 2'd0;
            wptr  <= '0;
            cnt   <= '0;
            lanes <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (bidx == 2'd3) begin
              bidx  <= 2'd0;
              lanes <= '0;
              wptr  <= wptr + ADDR_W'(1);
              cnt   <= cnt + (ADDR_W+1)'(1);
            end else begin
              bidx <= bidx + 2'd1;
              case (bidx)
                2'd0:    lanes[7:0]   <= i_ld_data;
                2'd1:    lanes[15:8]  <= i_ld_data;
                default: lanes[23:16] <= i_ld_data;
              endcase
            end
          end
          // A concurrent start keeps the load open.
          if (i_ld_done && !i_ld_start) begin
            state <= (bidx != 2'd0) ? S_FLUSH : S_RUN;
          end
        end
        default: begin
          state <= S_RUN;
          bidx  <= 2'd0;
          lanes <= '0;
          wptr  <= wptr + ADDR_W'(1);
          cnt   <= cnt + (ADDR_W+1)'(1);
        end
      endcase
    end
  end

`ifdef NANO_IMEM_BOUNDS_CHECK_EN
  logic oor;

  assign oor = (|i_pc[31:ADDR_W]) ||
               ({1'b0, i_pc[ADDR_W-1:0]} >= cnt);

  assign o_inst = (state == S_RUN && !oor) ?
                  mem[i_pc[ADDR_W-1:0]] : NOP;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (i_ld_start) begin
      o_err <= 1'b0;
    end else if (state == S_RUN && oor) begin
      o_err <= 1'b1;
    end
  end
`else
  logic pc_unused;

  assign pc_unused = ^i_pc[31:ADDR_W];
  assign o_inst    = (state == S_RUN) ?
                     mem[i_pc[ADDR_W-1:0]] : NOP;
  assign o_err     = 1'b0;
`endif

endmodule

// File: doc/nano_imem.md
NANO_IMEM -- requirements
Module: nano_imem

Interface
REQ-001 Parameter DEPTH, default 256, instruction memory depth in 32-bit words; SHALL be a power of two.
REQ-002 Parameter ADDR_W, default 8, word index width; SHALL equal log2(DEPTH).
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_ld_start  input  1  begins a program load.
REQ-006 i_ld_valid  input  1  load byte valid.
REQ-007 i_ld_data  input  8  load byte; little-endian within each word.
REQ-008 o_ld_ready  output  1  load byte accepted when high with i_ld_valid.
REQ-009 i_ld_done  input  1  ends the program load.
REQ-010 i_pc  input  32  core fetch word address; the core increments it by 1 per instruction.
REQ-011 o_inst  output  32  instruction for i_pc.
REQ-012 o_core_rst  output  1  holds the core in reset while high.
REQ-013 o_load_cnt  output  ADDR_W+1  count of words written by the last load.
REQ-014 o_err  output  1  sticky out-of-range fetch flag.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, FLUSH and RUN.
REQ-016 IDLE->LOAD on i_ld_start: clear the word pointer, byte index and o_load_cnt.
REQ-017 LOAD->FLUSH on i_ld_done when the byte index is nonzero; LOAD->RUN on i_ld_done when the byte index is zero.
REQ-018 FLUSH SHALL write the partial word with the missing upper bytes zero-filled, increment o_load_cnt, and go to RUN after exactly 1 cycle.
REQ-019 RUN->LOAD on i_ld_start, with the same clearing as REQ-016.
REQ-020 If i_ld_start and i_ld_done are asserted in the same cycle, i_ld_start SHALL win.
REQ-021 i_ld_done in IDLE or RUN SHALL be ignored.
REQ-022 In LOAD, each accepted byte fills byte lane = byte index and advances the byte index 0..3.
REQ-023 On the 4th byte of a word, the assembled word SHALL be written at the word pointer in that same edge; the word pointer and o_load_cnt increment, and the byte index wraps to 0.
REQ-024 o_ld_ready SHALL be high only in LOAD with o_load_cnt < DEPTH.
- At full (o_load_cnt == DEPTH), bytes are not accepted.
- i_ld_done still completes the load.
REQ-025 o_core_rst SHALL be high in IDLE, LOAD and FLUSH, and low only in RUN.
- The core therefore restarts at pc 0 on the first RUN cycle.
REQ-026 o_inst SHALL be combinational from i_pc (zero-latency fetch).
- In RUN: o_inst = mem[i_pc[ADDR_W-1:0]].
- Outside RUN: o_inst = 32'h00000013 (NOP).
REQ-027 Memory contents SHALL persist across loads except for the words rewritten.

Reset
REQ-028 i_rst SHALL force IDLE, byte index 0, word pointer 0, o_load_cnt 0, o_err 0, o_core_rst 1 and o_ld_ready 0.
REQ-029 i_rst SHALL take priority over all other inputs, including mid-load; a partial word pending at reset is discarded.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 Macro NANO_IMEM_BOUNDS_CHECK_EN, when defined, SHALL enable fetch bounds checking in RUN.
- A fetch is out of range if i_pc[31:ADDR_W] != 0 or i_pc[ADDR_W-1:0] >= o_load_cnt.
- An out-of-range fetch returns 32'h00000013 and sets o_err, which holds until i_rst or i_ld_start.
REQ-032 When NANO_IMEM_BOUNDS_CHECK_EN is not defined:
- Only the low ADDR_W bits of i_pc index memory.
- The raw word is returned.
- o_err SHALL be tied 0.

Verification
REQ-033 Reset, i_ld_start, bytes 13 00 10 00 93 00 20 00, i_ld_done -> mem[0]=32'h00100013, mem[1]=32'h00200093, o_load_cnt=2, o_core_rst falls 1 cycle after done.
REQ-034 Load 5 bytes AA BB CC DD EE, then i_ld_done -> FLUSH writes mem[1]=32'h000000EE, o_load_cnt=2, RUN after 1 cycle.
REQ-035 DEPTH=4, stream 20 bytes with i_ld_valid held high -> o_ld_ready drops after byte 16, o_load_cnt=4, the last 4 bytes are not accepted.
REQ-036 i_rst pulsed after 3 load bytes -> IDLE, o_load_cnt=0, o_core_rst=1, mem[0] unchanged.
REQ-037 i_ld_start and i_ld_done in the same cycle while in RUN -> LOAD entered, o_core_rst=1, o_load_cnt=0.
REQ-038 With NANO_IMEM_BOUNDS_CHECK_EN, 2 words loaded, i_pc=2 -> o_inst=32'h00000013, o_err=1 until the next i_ld_start; without the macro -> o_inst=mem[2], o_err=0.
